// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// default buffer depth and the buffered entry layout.
package fetch_pkg;

   localparam int FETCH_DEPTH = 4;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] WAIT    = 2'd2;
   localparam logic [1:0] DISCARD = 2'd3;

   // One buffered fetch: the instruction together with the address it came from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH x 64-bit circular queue with push, pop and flush.
// The head is read combinationally so a pushed entry is visible the next cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  wdata,
   output fetch_entry_t  head,
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [CW-1:0]  count_reg;
   logic           push_ok;
   logic           pop_ok;

   assign pop_ok  = pop && (count_reg != '0);
   assign push_ok = push && ((count_reg != FULL) || pop_ok);

   // Flush wins over a simultaneous push or pop; pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   assign head  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
   assign count = count_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetch FSM in front of a
// small buffer, with branch flush and program-counter step handshake.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   pc_in,
   input  logic          branch_taken,
   output logic          pc_advance,
   output logic          imem_req,
   output logic [31:0]   imem_addr,
   input  logic          imem_gnt,
   input  logic          imem_rvalid,
   input  logic [31:0]   imem_rdata,
   output logic          instr_valid,
   output logic [31:0]   instr_out,
   output logic [31:0]   instr_pc_out,
   input  logic          instr_ready,
   output logic [CW-1:0] buf_count
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [1:0]    state_reg;
   logic [1:0]    state_next;
   logic [31:0]   fetch_addr_reg;
   logic [31:0]   fetch_addr_next;
   logic          flush_pending_reg;
   logic          flush_pending_next;
   logic          push;
   fetch_entry_t  push_entry;
   fetch_entry_t  head_entry;
   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg         <= IDLE;
         fetch_addr_reg    <= '0;
         flush_pending_reg <= 1'b0;
      end else begin
         state_reg         <= state_next;
         fetch_addr_reg    <= fetch_addr_next;
         flush_pending_reg <= flush_pending_next;
      end
   end

   // Only one request is ever in flight, so a fetch that leaves IDLE with a
   // free slot still has that slot when its data returns.
   always_comb begin
      state_next         = state_reg;
      fetch_addr_next    = fetch_addr_reg;
      flush_pending_next = flush_pending_reg;
      case (state_reg)
         IDLE: begin
            if (!branch_taken && (count < FULL)) begin
               fetch_addr_next = pc_in;
               state_next      = REQ;
            end
         end
         REQ: begin
            // The request must stay up until granted; a flush seen meanwhile
            // is remembered so the granted data is thrown away.
            if (imem_gnt) begin
               state_next         = (branch_taken || flush_pending_reg) ? DISCARD : WAIT;
               flush_pending_next = 1'b0;
            end else if (branch_taken) begin
               flush_pending_next = 1'b1;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_next = IDLE;
            end else if (branch_taken) begin
               state_next = DISCARD;
            end
         end
         DISCARD: begin
            if (imem_rvalid) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign imem_req   = (state_reg == REQ);
   assign imem_addr  = fetch_addr_reg;
   assign pc_advance = imem_req && imem_gnt && !branch_taken && !flush_pending_reg;

   assign push       = (state_reg == WAIT) && imem_rvalid && !branch_taken;
   assign push_entry = '{pc: fetch_addr_reg, instr: imem_rdata};

   fetch_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (instr_ready),
      .flush (branch_taken),
      .wdata (push_entry),
      .head  (head_entry),
      .count (count)
   );

   assign buf_count    = count;
   assign instr_valid  = (count != '0);
   assign instr_out    = head_entry.instr;
   assign instr_pc_out = head_entry.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: bench-side program counter and
// memory models, expected program-order stream checked by a separate monitor.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_in = '0;
   logic        branch_taken = 1'b0;
   logic        pc_advance;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] instr_pc_out;
   logic        instr_ready = 1'b0;
   logic [2:0]  buf_count;

   instruction_fetch_unit #(.DEPTH(4), .CW(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_in        (pc_in),
      .branch_taken (branch_taken),
      .pc_advance   (pc_advance),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr_out    (instr_out),
      .instr_pc_out (instr_pc_out),
      .instr_ready  (instr_ready),
      .buf_count    (buf_count)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Environment knobs
   int          gnt_mode   = 1;   // 0 never, 1 always, 2 random, 3 one cycle after req
   int          ready_mode = 0;   // 0 never, 1 always, 2 random
   int          lat_min    = 0;
   int          lat_max    = 0;
   bit          rand_br    = 1'b0;
   bit          br_req     = 1'b0;
   logic [31:0] br_tgt     = '0;

   // Program counter and memory models
   logic [31:0] pc_m = '0;
   logic [63:0] exp_q[$];
   logic [31:0] seen_pc[$];
   bit          mem_out  = 1'b0;
   int          mem_cd   = 0;
   logic [31:0] mem_addr = '0;
   int          req_age  = 0;
   int          adv_count = 0;
   bit          prev_wait_gnt = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] br_tgt_eff = '0;

   bit          s_req, s_gnt, s_adv, s_rvalid, s_br;
   logic [31:0] s_addr;
   logic [63:0] mon_e;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check, then advance the models after posedge.
   task automatic cycle();
      @(negedge clk);
      pc_in = pc_m;
      case (gnt_mode)
         0:       imem_gnt = 1'b0;
         1:       imem_gnt = 1'b1;
         2:       imem_gnt = ($urandom_range(0, 2) != 0);
         default: imem_gnt = (req_age >= 1);
      endcase
      imem_rvalid = mem_out && (mem_cd == 0);
      imem_rdata  = imem_rvalid ? memf(mem_addr) : $urandom;
      branch_taken = br_req || (rand_br && !rst && ($urandom_range(0, 15) == 0));
      if (branch_taken) begin
         br_tgt_eff = br_req ? br_tgt : ($urandom & 32'h0000_FFFC);
      end
      br_req = 1'b0;
      instr_ready = (ready_mode == 1) || ((ready_mode == 2) && ($urandom_range(0, 1) == 1));
      if (branch_taken) begin
         instr_ready = 1'b0;
      end
      #1;
      s_req = imem_req; s_gnt = imem_gnt; s_adv = pc_advance;
      s_addr = imem_addr; s_rvalid = imem_rvalid; s_br = branch_taken;
      if (!rst) begin
         if (prev_wait_gnt) begin
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_stable", imem_addr, prev_addr);
         end
         if (branch_taken) begin
            chk("adv_in_branch", 32'(pc_advance), 32'd0);
         end
         if (pc_advance) begin
            chk("adv_on_grant", 32'(imem_req && imem_gnt), 32'd1);
            chk("adv_addr", imem_addr, pc_m);
         end
         chk("valid_vs_count", 32'(instr_valid), 32'(buf_count != 3'd0));
      end else begin
         chk("rst_req", 32'(imem_req), 32'd0);
         chk("rst_adv", 32'(pc_advance), 32'd0);
         chk("rst_valid", 32'(instr_valid), 32'd0);
         chk("rst_instr", instr_out, 32'd0);
         chk("rst_pc", instr_pc_out, 32'd0);
      end
      prev_wait_gnt = !rst && imem_req && !imem_gnt;
      prev_addr     = imem_addr;
      @(posedge clk);
      #1;
      if (s_rvalid) begin
         mem_out = 1'b0;
      end else if (mem_out && (mem_cd > 0)) begin
         mem_cd--;
      end
      if (rst) begin
         pc_m = '0;
         exp_q.delete();
         req_age = 0;
      end else begin
         if (s_req && s_gnt) begin
            chk("one_outstanding", 32'(mem_out), 32'd0);
            mem_out  = 1'b1;
            mem_addr = s_addr;
            mem_cd   = $urandom_range(lat_min, lat_max);
         end
         req_age = (s_req && !s_gnt) ? req_age + 1 : 0;
         if (s_br) begin
            pc_m = br_tgt_eff;
            exp_q.delete();
         end else if (s_adv) begin
            exp_q.push_back({pc_m, memf(pc_m)});
            pc_m = pc_m + 32'd4;
            adv_count++;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_out = 1'b0;
      prev_wait_gnt = 1'b0;
      repeat (3) cycle();
      rst = 1'b0;
      adv_count = 0;
   endtask

   // Monitor: every consumed head must be the next entry in program order.
   always @(negedge clk) begin
      #2;
      if (!rst && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_instr: got pc %h, expected no entry", instr_pc_out);
         end else begin
            mon_e = exp_q.pop_front();
            chk("instr_pc", instr_pc_out, mon_e[63:32]);
            chk("instr_data", instr_out, mon_e[31:0]);
            seen_pc.push_back(instr_pc_out);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish, expected finish within 1 ms");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic [31:0] held;

      // Basic fetch: grant one cycle after request, data two cycles after grant
      gnt_mode = 3; lat_min = 1; lat_max = 1; ready_mode = 0;
      do_reset();
      for (n = 0; n < 20 && !instr_valid; n++) cycle();
      chk("t_basic_wait", 32'(n < 20), 32'd1);
      chk("t_basic_latency", 32'(s_rvalid), 32'd1);
      chk("t_basic_adv", 32'(adv_count), 32'd1);
      chk("t_basic_pc", instr_pc_out, 32'h0);
      chk("t_basic_instr", instr_out, 32'h0000_0013);

      // Fill the buffer with no consumer, then free one slot
      gnt_mode = 1; lat_min = 0; lat_max = 2; ready_mode = 0;
      do_reset();
      repeat (40) cycle();
      chk("t_full_count", 32'(buf_count), 32'd4);
      chk("t_full_noreq", 32'(s_req), 32'd0);
      chk("t_full_adv", 32'(adv_count), 32'd4);
      ready_mode = 1;
      cycle();
      ready_mode = 0;
      chk("t_full_pop", 32'(buf_count), 32'd3);
      for (n = 0; n < 10 && !s_req; n++) cycle();
      chk("t_full_req_wait", 32'(n < 10), 32'd1);
      chk("t_full_next_addr", s_addr, 32'h10);

      // Branch while waiting for data with two entries buffered
      gnt_mode = 1; lat_min = 4; lat_max = 4; ready_mode = 0;
      do_reset();
      for (n = 0; n < 60 && !(buf_count == 3'd2 && mem_out); n++) cycle();
      chk("t_wait_br_setup", 32'(n < 60), 32'd1);
      br_req = 1'b1; br_tgt = 32'h0000_0100;
      cycle();
      chk("t_wait_br_flush", 32'(buf_count), 32'd0);
      for (n = 0; n < 20 && !s_adv; n++) cycle();
      chk("t_wait_br_adv_wait", 32'(n < 20), 32'd1);
      chk("t_wait_br_addr", s_addr, 32'h0000_0100);
      chk("t_wait_br_dropped", 32'(buf_count), 32'd0);
      ready_mode = 1;
      repeat (20) cycle();

      // Branch while the request is still waiting for a grant
      gnt_mode = 0; lat_min = 1; lat_max = 1; ready_mode = 0;
      do_reset();
      for (n = 0; n < 10 && !s_req; n++) cycle();
      chk("t_req_br_setup", 32'(n < 10), 32'd1);
      held = s_addr;
      br_req = 1'b1; br_tgt = 32'h0000_0200;
      cycle();
      repeat (3) begin
         cycle();
         chk("t_req_br_req", 32'(s_req), 32'd1);
         chk("t_req_br_addr", s_addr, held);
      end
      gnt_mode = 1;
      cycle();
      chk("t_req_br_grant", 32'(s_req && s_gnt), 32'd1);
      chk("t_req_br_noadv", 32'(s_adv), 32'd0);
      for (n = 0; n < 30 && !instr_valid; n++) cycle();
      chk("t_req_br_wait", 32'(n < 30), 32'd1);
      chk("t_req_br_pc", instr_pc_out, 32'h0000_0200);
      chk("t_req_br_instr", instr_out, memf(32'h0000_0200));

      // Push and pop in the same cycle keep the count and the order
      gnt_mode = 1; lat_min = 1; lat_max = 1; ready_mode = 0;
      do_reset();
      for (n = 0; n < 30 && !(buf_count == 3'd1 && mem_out && mem_cd == 0); n++) cycle();
      chk("t_pp_setup", 32'(n < 30), 32'd1);
      seen_pc.delete();
      ready_mode = 1;
      cycle();
      chk("t_pp_count", 32'(buf_count), 32'd1);
      chk("t_pp_head", instr_pc_out, 32'h4);
      repeat (15) cycle();
      chk("t_pp_seen", 32'(seen_pc.size() >= 3), 32'd1);
      if (seen_pc.size() >= 3) begin
         chk("t_pp_order0", seen_pc[0], 32'h0);
         chk("t_pp_order1", seen_pc[1], 32'h4);
         chk("t_pp_order2", seen_pc[2], 32'h8);
      end

      // Reset asserted mid-WAIT for 100 ns, stale data returned after release
      gnt_mode = 1; lat_min = 3; lat_max = 3; ready_mode = 0;
      do_reset();
      for (n = 0; n < 20 && !(mem_out && buf_count == 3'd1); n++) cycle();
      chk("t_rst_setup", 32'(n < 20), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t_rst_async_req", 32'(imem_req), 32'd0);
      chk("t_rst_async_valid", 32'(instr_valid), 32'd0);
      chk("t_rst_async_count", 32'(buf_count), 32'd0);
      prev_wait_gnt = 1'b0;
      repeat (10) cycle();
      rst = 1'b0;
      adv_count = 0;
      mem_out = 1'b1; mem_cd = 0;
      for (n = 0; n < 20 && !instr_valid; n++) cycle();
      chk("t_rst_wait", 32'(n < 20), 32'd1);
      chk("t_rst_pc", instr_pc_out, 32'h0);
      chk("t_rst_instr", instr_out, memf(32'h0));
      chk("t_rst_count", 32'(buf_count), 32'd1);

      // Randomized traffic: random grants, latencies, consumer and branches
      gnt_mode = 2; lat_min = 0; lat_max = 3; ready_mode = 2;
      do_reset();
      rand_br = 1'b1;
      repeat (3000) cycle();
      rand_br = 1'b0;
      ready_mode = 1;
      repeat (30) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
